// File: rtl/gates_sweep_ctrl.sv
// Drives the four {A,B} vectors into a two-input gate block, lets each settle, captures X/Y/Z
// and scores them against truth tables. Optional GATES_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gates_sweep_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter logic [3:0]  EXP_X  = 4'b1000,
  parameter logic [3:0]  EXP_Y  = 4'b1110,
  parameter logic [3:0]  EXP_Z  = 4'b0110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        A,
  output logic        B,
  input  logic        X,
  input  logic        Y,
  input  logic        Z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_mask,
  output logic [11:0] result,
  output logic [2:0]  err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        a_q, b_q;
  logic [1:0]  ab_d;
  logic [11:0] result_q, result_d;
  logic [3:0]  fail_mask_q, fail_mask_d;
  logic [2:0]  err_cnt_q, err_cnt_d;
  logic [2:0]  xyz, exp_xyz;
  logic        mismatch, stop_early;

  assign xyz      = {X, Y, Z};
  assign exp_xyz  = {EXP_X[k_q], EXP_Y[k_q], EXP_Z[k_q]};
  assign mismatch = (xyz != exp_xyz);

`ifdef GATES_SWEEP_STOP_ON_FAIL_EN
  assign stop_early = mismatch;
`else
  assign stop_early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_DRIVE;
      S_DRIVE:  if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
      S_SAMPLE: state_d = ((k_q == 2'd3) || stop_early) ? S_DONE : S_DRIVE;
      S_DONE:   if (start) state_d = S_DRIVE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    done        = (state_q == S_DONE);
    pass        = done && (err_cnt_q == 3'd0);
    k_d         = k_q;
    cnt_d       = 8'd0;
    result_d    = result_q;
    fail_mask_d = fail_mask_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        k_d = 2'd0;
        if (start || state_q == S_IDLE) begin
          result_d    = 12'd0;
          fail_mask_d = 4'd0;
          err_cnt_d   = 3'd0;
        end
      end
      S_DRIVE: cnt_d = cnt_q + 8'd1;
      S_SAMPLE: begin
        result_d[3*k_q +: 3] = xyz;
        if (mismatch) begin
          fail_mask_d[k_q] = 1'b1;
          err_cnt_d        = err_cnt_q + 3'd1;
        end
        k_d = k_q + 2'd1;
      end
      default: ;
    endcase
    // Stimulus follows the next vector index so A/B change on the edge leaving SAMPLE.
    ab_d = ((state_d == S_DRIVE) || (state_d == S_SAMPLE)) ? k_d : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q         <= 2'd0;
      cnt_q       <= 8'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      result_q    <= 12'd0;
      fail_mask_q <= 4'd0;
      err_cnt_q   <= 3'd0;
    end else begin
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      a_q         <= ab_d[1];
      b_q         <= ab_d[0];
      result_q    <= result_d;
      fail_mask_q <= fail_mask_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign result    = result_q;
  assign fail_mask = fail_mask_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gates_sweep_ctrl.sv
// Directed bench: three sweep controllers (SETTLE 2, 1, 255) around AND/OR/XOR gate models
// with injectable stuck-at faults on Z (SETTLE 2) and Y (SETTLE 255).
module tb_gates_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef GATES_SWEEP_STOP_ON_FAIL_EN
  localparam int          Z_CYC  = 6;
  localparam logic [3:0]  Z_MASK = 4'b0010;
  localparam logic [2:0]  Z_ERR  = 3'd1;
  localparam logic [11:0] Z_RES  = 12'b000_000_010_000;
  localparam int          Y_CYC  = 256;
`else
  localparam int          Z_CYC  = 12;
  localparam logic [3:0]  Z_MASK = 4'b0110;
  localparam logic [2:0]  Z_ERR  = 3'd2;
  localparam logic [11:0] Z_RES  = 12'b110_010_010_000;
  localparam int          Y_CYC  = 1024;
`endif

  // SETTLE=2 instance, Z may be forced low
  logic s2 = 1'b0, z_stuck = 1'b0;
  logic a2, b2, busy2, done2, pass2;
  logic [3:0] mask2; logic [11:0] res2; logic [2:0] err2;
  gates_sweep_ctrl #(.SETTLE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .A(a2), .B(b2),
    .X(a2 & b2), .Y(a2 | b2), .Z(z_stuck ? 1'b0 : (a2 ^ b2)),
    .busy(busy2), .done(done2), .pass(pass2), .fail_mask(mask2), .result(res2), .err_cnt(err2));

  // SETTLE=1 instance, fault-free
  logic s1 = 1'b0;
  logic a1, b1, busy1, done1, pass1;
  logic [3:0] mask1; logic [11:0] res1; logic [2:0] err1;
  gates_sweep_ctrl #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .A(a1), .B(b1),
    .X(a1 & b1), .Y(a1 | b1), .Z(a1 ^ b1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1), .result(res1), .err_cnt(err1));

  // SETTLE=255 instance, Y stuck at 1
  logic s255 = 1'b0;
  logic a255, b255, busy255, done255, pass255;
  logic [3:0] mask255; logic [11:0] res255; logic [2:0] err255;
  gates_sweep_ctrl #(.SETTLE(255)) u255 (
    .clk(clk), .rst_n(rst_n), .start(s255), .A(a255), .B(b255),
    .X(a255 & b255), .Y(1'b1), .Z(a255 ^ b255),
    .busy(busy255), .done(done255), .pass(pass255), .fail_mask(mask255), .result(res255), .err_cnt(err255));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cyc;

    #12;
    chk("rst A", a2, 0);
    chk("rst B", b2, 0);
    chk("rst busy", busy2, 0);
    chk("rst done", done2, 0);
    chk("rst pass", pass2, 0);
    chk("rst mask", mask2, 0);
    chk("rst result", res2, 0);
    chk("rst err", err2, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle without start", busy2, 0);

    // Clean sweep, SETTLE=2, with a start pulse landing in DRIVE
    s2 = 1'b1; tick(); s2 = 1'b0;
    chk("start busy", busy2, 1);
    chk("start AB", {a2, b2}, 0);
    for (int i = 1; i <= 12; i++) begin
      if (i == 1) s2 = 1'b1;
      if (i == 2) s2 = 1'b0;
      tick();
      chk("busy/done exclusive", busy2 & done2, 0);
      if (i < 12) chk("not yet done", done2, 0);
      if (i == 6) chk("slot1 partial", res2, 12'b000_000_011_000);
    end
    chk("clean done@12", done2, 1);
    chk("clean busy", busy2, 0);
    chk("clean result", res2, 12'b110_011_011_000);
    chk("clean pass", pass2, 1);
    chk("clean err", err2, 0);
    chk("clean mask", mask2, 0);
    tick(); tick();
    chk("done held", done2, 1);
    chk("done AB", {a2, b2}, 0);
    chk("result held", res2, 12'b110_011_011_000);

    // Restart from DONE with Z stuck low
    z_stuck = 1'b1;
    s2 = 1'b1; tick(); s2 = 1'b0;
    chk("restart result clr", res2, 0);
    chk("restart mask clr", mask2, 0);
    chk("restart err clr", err2, 0);
    chk("restart busy", busy2, 1);
    cyc = 0;
    while (!done2 && cyc < 40) begin tick(); cyc++; end
    chk("zstuck cycles", cyc, Z_CYC);
    chk("zstuck mask", mask2, Z_MASK);
    chk("zstuck err", err2, Z_ERR);
    chk("zstuck pass", pass2, 0);
    chk("zstuck result", res2, Z_RES);
    z_stuck = 1'b0;

    // SETTLE=1: each vector held two cycles
    s1 = 1'b1; tick(); s1 = 1'b0;
    for (int j = 0; j < 9; j++) begin
      if (j < 8) chk("settle1 AB", {a1, b1}, j >> 1);
      else begin
        chk("settle1 done@8", done1, 1);
        chk("settle1 pass", pass1, 1);
        chk("settle1 result", res1, 12'b110_011_011_000);
      end
      if (j < 8) tick();
    end

    // Reset during the third vector
    s2 = 1'b1; tick(); s2 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("third vector AB", {a2, b2}, 2'b10);
    chk("partial result", res2, 12'b000_000_011_000);
    rst_n = 1'b0;
    #1;
    chk("midrst A", a2, 0);
    chk("midrst busy", busy2, 0);
    chk("midrst result", res2, 0);
    chk("midrst mask/err/done", {mask2, err2, done2, pass2}, 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("post-rst idle busy", busy2, 0);
    chk("post-rst idle done", done2, 0);

    // SETTLE=255 with Y stuck high
    chk("u255 idle", busy255 | done255, 0);
    s255 = 1'b1; tick(); s255 = 1'b0;
    cyc = 0;
    while (!done255 && cyc < 1100) begin tick(); cyc++; end
    chk("ystuck cycles", cyc, Y_CYC);
    chk("ystuck mask", mask255, 4'b0001);
    chk("ystuck err", err255, 1);
    chk("ystuck pass", pass255, 0);
    chk("ystuck slot0", res255[2:0], 3'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
